// File: rtl/mips_cpu_muldiv_if.sv
// HI/LO multiply-divide unit command and result bundle.
// Master drives the command; slave returns HI/LO and status.
interface mips_cpu_muldiv_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        write;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output a, b, op, write,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, op, write,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU, MTHI/MTLO,
// and 32-cycle restoring DIV/DIVU.
module mips_cpu_muldiv (
  input  logic clk,
  input  logic reset,
  mips_cpu_muldiv_if.slave bus
);

  typedef enum logic {IDLE, DIV} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        accept;
  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [32:0] shift;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_n;
  logic [31:0] quo_n;

  assign accept = bus.write && (state_q == IDLE);
  assign sgn    = ~bus.op[0];
  assign abs_a  = (sgn && bus.a[31]) ? -bus.a : bus.a;
  assign abs_b  = (sgn && bus.b[31]) ? -bus.b : bus.b;

  // Low 64 bits of the sign-extended product is the signed product.
  assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  assign shift = {rem_q, quo_q[31]};
  assign diff  = shift - {1'b0, dvs_q};
  assign ge    = ~diff[32];
  assign rem_n = ge ? diff[31:0] : shift[31:0];
  assign quo_n = {quo_q[30:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.op)
            3'b000: {hi_d, lo_d} = prod_s;
            3'b001: {hi_d, lo_d} = prod_u;
            3'b010, 3'b011: begin
              state_d = DIV;
              cnt_d   = 6'd0;
              rem_d   = 32'd0;
              quo_d   = abs_a;
              dvs_d   = abs_b;
              dvd_d   = bus.a;
              negq_d  = sgn & (bus.a[31] ^ bus.b[31]);
              negr_d  = sgn & bus.a[31];
            end
            3'b100: hi_d = bus.a;
            3'b101: lo_d = bus.a;
            3'b110, 3'b111: ;
          endcase
        end
      end
      DIV: begin
        cnt_d = cnt_q + 6'd1;
        rem_d = rem_n;
        quo_d = quo_n;
        if (cnt_q == 6'd31) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
          // Divide by zero: all-ones quotient, dividend as remainder.
          if (dvs_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = dvd_q;
          end else begin
            lo_d = negq_q ? -quo_n : quo_n;
            hi_d = negr_q ? -rem_n : rem_n;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      dvd_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == DIV);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv.
// Inputs change and outputs are sampled on the falling edge.
module tb_mips_cpu_muldiv;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic wait_div(input string tag,
                          input logic [31:0] hi_old,
                          input logic [31:0] lo_old);
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_hold_hi"}, bus.hi, hi_old);
      chk({tag, "_hold_lo"}, bus.lo, lo_old);
      @(negedge clk);
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    bus.write = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    #3 reset  = 1'b0;
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // MULT 7*6
    issue(3'b000, 32'd7, 32'd6);
    chk("mult76_hi", bus.hi, 32'h0000_0000);
    chk("mult76_lo", bus.lo, 32'h0000_002A);
    chk("mult76_busy", {31'd0, bus.busy}, 32'd0);

    // MULT -1*2
    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("multneg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("multneg_lo", bus.lo, 32'hFFFF_FFFE);

    // MULTU max*max
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_busy", {31'd0, bus.busy}, 32'd0);

    // MFLO/MFHI change nothing
    issue(3'b110, 32'hDEAD_BEEF, 32'd0);
    issue(3'b111, 32'hDEAD_BEEF, 32'd0);
    chk("mf_hi", bus.hi, 32'hFFFF_FFFE);
    chk("mf_lo", bus.lo, 32'h0000_0001);

    // DIV -7/2 with an MTLO attempt mid-division
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 32; i++) begin
      chk("div7_busy", {31'd0, bus.busy}, 32'd1);
      chk("div7_nodone", {31'd0, bus.done}, 32'd0);
      chk("div7_hold_hi", bus.hi, 32'hFFFF_FFFE);
      chk("div7_hold_lo", bus.lo, 32'h0000_0001);
      if (i == 4) begin
        bus.op    = 3'b101;
        bus.a     = 32'h1234_5678;
        bus.write = 1'b1;
      end else begin
        bus.write = 1'b0;
      end
      @(negedge clk);
    end
    chk("div7_done", {31'd0, bus.done}, 32'd1);
    chk("div7_idle", {31'd0, bus.busy}, 32'd0);
    chk("div7_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div7_hi", bus.hi, 32'hFFFF_FFFF);

    // MTLO in the done cycle is accepted
    issue(3'b101, 32'h1234_5678, 32'd0);
    chk("div7_pulse", {31'd0, bus.done}, 32'd0);
    chk("mtlo_lo", bus.lo, 32'h1234_5678);
    chk("mtlo_hi", bus.hi, 32'hFFFF_FFFF);

    // MTHI
    issue(3'b100, 32'h0000_CAFE, 32'd0);
    chk("mthi_hi", bus.hi, 32'h0000_CAFE);
    chk("mthi_lo", bus.lo, 32'h1234_5678);

    // DIVU by zero
    issue(3'b011, 32'd100, 32'd0);
    wait_div("divu0", 32'h0000_CAFE, 32'h1234_5678);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'h0000_0064);

    // DIV overflow case
    @(negedge clk);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_div("divovf", 32'h0000_0064, 32'hFFFF_FFFF);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0000_0000);

    // DIVU 1000/7 -> q=142 r=6
    issue(3'b011, 32'd1000, 32'd7);
    wait_div("divu", 32'h0000_0000, 32'h8000_0000);
    chk("divu_lo", bus.lo, 32'd142);
    chk("divu_hi", bus.hi, 32'd6);

    // DIV 7/-2 -> q=-3 r=1
    issue(3'b010, 32'd7, 32'hFFFF_FFFE);
    wait_div("divsn", 32'd6, 32'd142);
    chk("divsn_lo", bus.lo, 32'hFFFF_FFFD);
    chk("divsn_hi", bus.hi, 32'd1);

    // Reset 10 cycles into DIVU
    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("postrst_nodone", {31'd0, bus.done}, 32'd0);
    end
    chk("postrst_busy", {31'd0, bus.busy}, 32'd0);

    // MULTU 3*5 after reset
    issue(3'b001, 32'd3, 32'd5);
    chk("multu35_lo", bus.lo, 32'd15);
    chk("multu35_hi", bus.hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 The block SHALL have the port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port: reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have the port: a  input  32  operand rs; the dividend for DIV and DIVU.
REQ-004 The block SHALL have the port: b  input  32  operand rt; the divisor for DIV and DIVU.
REQ-005 The block SHALL have the port: op  input  3  operation code, decoded as 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFLO, 111 MFHI.
REQ-006 The block SHALL have the port: write  input  1  command strobe; the block samples op, a and b when it is high at a rising edge.
REQ-007 The block SHALL have the port: hi  output  32  the HI register, driven directly from a flop.
REQ-008 The block SHALL have the port: lo  output  32  the LO register, driven directly from a flop.
REQ-009 The block SHALL have the port: busy  output  1  high while a division is in progress; upstream stalls HI/LO instructions while it is high.
REQ-010 The block SHALL have the port: done  output  1  one-cycle pulse signalling that a division has completed.

Function
REQ-011 A command SHALL be accepted only on a rising edge where write=1 and busy=0; write=1 while busy=1 SHALL be ignored with no state change.
REQ-012 MULT SHALL form the 64-bit signed product and MULTU the 64-bit unsigned product; on the accepting edge {hi,lo} SHALL be loaded with that product; busy SHALL stay 0; zero extra latency.
REQ-013 MTHI SHALL load hi<=a and MTLO SHALL load lo<=a on the accepting edge, leaving the other register unchanged.
REQ-014 MFLO and MFHI SHALL cause no state change, because the downstream ALU reads lo and hi combinationally.
REQ-015 State machine states SHALL be IDLE and DIV; an accepted DIV or DIVU command SHALL move the block IDLE->DIV and latch the operands.
REQ-016 Division SHALL be restoring, unsigned, 1 quotient bit per cycle, on operand magnitudes; a 6-bit counter SHALL count 32 iterations.
REQ-017 busy SHALL be 1 for exactly the 32 cycles after the accepting edge.
REQ-018 On the 32nd DIV-state edge the block SHALL write hi/lo, return to IDLE, drop busy, and assert done for the following single cycle.
REQ-019 During division, hi and lo SHALL hold their previous values.
REQ-020 For signed DIV, the quotient SHALL truncate toward zero and SHALL be negated when the operand signs differ.
REQ-021 For signed DIV, the remainder SHALL carry the sign of the dividend.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 For division by zero with DIV or DIVU, the block SHALL still take 32 cycles, then set lo=0xFFFFFFFF and hi=a, with raw bits for DIVU and the signed dividend value for DIV.
REQ-024 Results SHALL go to lo=quotient and hi=remainder.
REQ-025 done SHALL be 0 in all cycles other than the one completion cycle.
REQ-026 In the cycle done=1, busy=0 and a new command SHALL be acceptable.

Reset
REQ-027 reset=0 SHALL immediately and asynchronously force hi=0, lo=0, busy=0, done=0, state=IDLE and counter=0.
REQ-028 Reset asserted mid-division SHALL abort the division, discard the partial result and leave no pending done.
REQ-029 After reset deasserts, the first rising edge with write=1 SHALL be accepted normally.

Verification
REQ-030 The bench SHALL cover MULT with a=7, b=6 -> next cycle hi=0x00000000, lo=0x0000002A, busy=0 throughout.
REQ-031 The bench SHALL cover signed and unsigned multiply: MULT 0xFFFFFFFF*0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 The bench SHALL cover DIV with a=0xFFFFFFF9 (-7), b=2 -> busy high 32 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulse of exactly one cycle; hi/lo unchanged before completion.
REQ-033 The bench SHALL cover DIVU with a=100, b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 The bench SHALL cover MTLO 0x12345678 with write=1 during an active DIV -> ignored; the final lo equals the quotient; MTLO after done -> lo=0x12345678, hi unchanged.
REQ-035 The bench SHALL cover reset=0 asserted 10 cycles into DIVU -> hi=lo=0 and busy=0 at once, no done afterwards; then MULTU 3*5 -> lo=15.
